mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between instruction fetch (F stage) and load/store access (M stage) of the 5-stage RISC-V pipeline. Sequences at most one data access and one fetch per pipeline advance, and holds the F/D/E/M pipeline registers via their enable inputs while accesses are outstanding. Data access always precedes fetch, because the M-stage instruction is older. A wait-cycle watchdog completes hung accesses and flags a sticky bus error.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the F-stage fetch and the M-stage load/store.
// Issues the data access first (older instruction), then the fetch, and stalls the pipeline until both finish.
module mem_port_arbiter #(
    parameter int unsigned WAIT_MAX  = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    output logic        MemWE,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] InstrF,
    output logic [31:0] ReadDataM,
    output logic        Advance,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic in_wait;
    logic timeout;
    logic done;

    // A timed-out access completes exactly like an acked one, just with substitute data.
    assign in_wait = (state_q == DATA_WAIT) || (state_q == FETCH_WAIT);
    assign timeout = in_wait && !MemReady && (wait_cnt_q == WAIT_LIMIT);
    assign done    = in_wait && (MemReady || timeout);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        bus_err_d  = bus_err_q;
        MemReq     = 1'b1;
        MemAddr    = PCF;
        MemWD      = WriteDataM;
        MemWE      = 1'b0;
        Advance    = 1'b0;

        case (state_q)
            IDLE: begin
                wait_cnt_d = 8'd0;
                if (MemReqM) begin
                    MemAddr = ALUResultM;
                    MemWE   = MemWriteM;
                    state_d = DATA_WAIT;
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            DATA_WAIT: begin
                MemAddr = ALUResultM;
                MemWE   = MemWriteM;
                if (done) begin
                    if (!MemWriteM) begin
                        rdata_d = MemReady ? MemRData : 32'd0;
                    end
                    if (timeout) begin
                        bus_err_d = 1'b1;
                    end
                    wait_cnt_d = 8'd0;
                    state_d    = FETCH_WAIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            FETCH_WAIT: begin
                if (done) begin
                    instr_d = MemReady ? MemRData : NOP_INSTR;
                    if (timeout) begin
                        bus_err_d = 1'b1;
                    end
                    Advance    = !rst;
                    wait_cnt_d = 8'd0;
                    state_d    = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                wait_cnt_d = 8'd0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            instr_q    <= NOP_INSTR;
            rdata_q    <= 32'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign InstrF    = instr_q;
    assign ReadDataM = rdata_q;
    assign BusErr    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_MAX=4) with a small latency-programmable memory model.
module tb_mem_port_arbiter;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWD;
    logic        MemWE;
    logic [31:0] MemRData;
    logic        MemReady;
    logic [31:0] InstrF;
    logic [31:0] ReadDataM;
    logic        Advance;
    logic        BusErr;

    int vectors     = 0;
    int miscompares = 0;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_MAX(4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemReq(MemReq),
        .MemAddr(MemAddr), .MemWD(MemWD), .MemWE(MemWE), .MemRData(MemRData),
        .MemReady(MemReady), .InstrF(InstrF), .ReadDataM(ReadDataM),
        .Advance(Advance), .BusErr(BusErr)
    );

    // Memory model: acks `lat` cycles after a request starts; age restarts after each ack.
    logic        ack_en;
    int          lat;
    int          age;
    logic [31:0] word_2004;

    assign MemReady = ack_en && MemReq && (age == lat);

    always_comb begin
        MemRData = 32'd0;
        case (MemAddr)
            32'h0000_0100: MemRData = 32'h00500093;
            32'h0000_0104: MemRData = 32'h00100113;
            32'h0000_2000: MemRData = 32'hDEADBEEF;
            32'h0000_2004: MemRData = word_2004;
            default:       MemRData = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (rst || !MemReq || MemReady || !ack_en) age <= 0;
        else age <= age + 1;
        if (rst) word_2004 <= 32'd0;
        else if (MemReady && MemWE && MemAddr == 32'h0000_2004) word_2004 <= MemWD;
    end

    // driver / checker tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; PCF = 32'h100; MemReqM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = 32'd0; WriteDataM = 32'd0; ack_en = 1'b1; lat = 1;
        tick();
        tick();
        chk("rst_advance", {31'd0, Advance}, 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_buserr", {31'd0, BusErr}, 32'd0);

        // fetch only, 1-cycle ack
        rst = 1'b0;
        #1;
        chk("f_c1_req", {31'd0, MemReq}, 32'd1);
        chk("f_c1_addr", MemAddr, 32'h100);
        chk("f_c1_we", {31'd0, MemWE}, 32'd0);
        chk("f_c1_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("f_c2_addr", MemAddr, 32'h100);
        chk("f_c2_adv", {31'd0, Advance}, 32'd1);
        chk("f_c2_instr_old", InstrF, NOP);
        tick();
        chk("f_c3_instr", InstrF, 32'h00500093);
        chk("f_c3_adv", {31'd0, Advance}, 32'd0);
        chk("f_c3_req", {31'd0, MemReq}, 32'd1);

        // load then fetch
        MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h2000; PCF = 32'h104;
        #1;
        chk("ld_c1_addr", MemAddr, 32'h2000);
        chk("ld_c1_we", {31'd0, MemWE}, 32'd0);
        chk("ld_c1_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("ld_c2_addr", MemAddr, 32'h2000);
        chk("ld_c2_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("ld_c3_rdata", ReadDataM, 32'hDEADBEEF);
        chk("ld_c3_addr", MemAddr, 32'h104);
        chk("ld_c3_req", {31'd0, MemReq}, 32'd1);
        chk("ld_c3_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("ld_c4_adv", {31'd0, Advance}, 32'd1);
        tick();
        chk("ld_c5_adv", {31'd0, Advance}, 32'd0);
        chk("ld_c5_instr", InstrF, 32'h00100113);

        // store then fetch
        MemWriteM = 1'b1; ALUResultM = 32'h2004; WriteDataM = 32'h12345678; PCF = 32'h100;
        #1;
        chk("st_c1_we", {31'd0, MemWE}, 32'd1);
        chk("st_c1_wd", MemWD, 32'h12345678);
        chk("st_c1_addr", MemAddr, 32'h2004);
        tick();
        chk("st_c2_we", {31'd0, MemWE}, 32'd1);
        tick();
        chk("st_c3_we", {31'd0, MemWE}, 32'd0);
        chk("st_c3_rdata", ReadDataM, 32'hDEADBEEF);
        chk("st_c3_mem", word_2004, 32'h12345678);
        tick();
        chk("st_c4_adv", {31'd0, Advance}, 32'd1);
        tick();
        chk("st_c5_instr", InstrF, 32'h00500093);

        // load with 5-cycle ack (lands on the last permitted wait cycle), then 4-cycle fetch
        MemWriteM = 1'b0; ALUResultM = 32'h2004; lat = 5;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("vl_adv", {31'd0, Advance}, 32'd0);
            chk("vl_addr", MemAddr, 32'h2004);
            tick();
        end
        chk("vl_ack", {31'd0, MemReady}, 32'd1);
        chk("vl_ack_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("vl_rdata", ReadDataM, 32'h12345678);
        chk("vl_buserr_d", {31'd0, BusErr}, 32'd0);
        lat = 4;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("vl_f_adv", {31'd0, Advance}, 32'd0);
            chk("vl_f_addr", MemAddr, 32'h100);
            tick();
        end
        chk("vl_f_adv_done", {31'd0, Advance}, 32'd1);
        tick();
        chk("vl_instr", InstrF, 32'h00500093);
        chk("vl_buserr_f", {31'd0, BusErr}, 32'd0);
        chk("vl_no_dup", {31'd0, Advance}, 32'd0);

        // fetch timeout: memory silent
        MemReqM = 1'b0; PCF = 32'h104; ack_en = 1'b0; lat = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to_f_adv", {31'd0, Advance}, 32'd0);
            tick();
        end
        chk("to_f_adv_done", {31'd0, Advance}, 32'd1);
        chk("to_f_buserr_pre", {31'd0, BusErr}, 32'd0);
        tick();
        chk("to_f_instr", InstrF, NOP);
        chk("to_f_buserr", {31'd0, BusErr}, 32'd1);
        ack_en = 1'b1;
        tick();
        chk("to_f_next_adv", {31'd0, Advance}, 32'd1);
        tick();
        chk("to_f_next_instr", InstrF, 32'h00100113);
        chk("to_f_sticky", {31'd0, BusErr}, 32'd1);

        // load timeout: ReadDataM forced to 0, fetch still performed
        MemReqM = 1'b1; ALUResultM = 32'h2000; ack_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("to_d_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("to_d_rdata", ReadDataM, 32'd0);
        chk("to_d_faddr", MemAddr, 32'h104);
        ack_en = 1'b1;
        #1;
        chk("to_d_f_adv0", {31'd0, Advance}, 32'd0);
        tick();
        chk("to_d_f_adv1", {31'd0, Advance}, 32'd1);
        tick();
        chk("to_d_sticky", {31'd0, BusErr}, 32'd1);

        // reset in the middle of a data access
        lat = 3;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mr_adv_in_rst", {31'd0, Advance}, 32'd0);
        tick();
        chk("mr_adv", {31'd0, Advance}, 32'd0);
        chk("mr_buserr", {31'd0, BusErr}, 32'd0);
        chk("mr_instr", InstrF, NOP);
        chk("mr_rdata", ReadDataM, 32'd0);
        rst = 1'b0; MemReqM = 1'b0; lat = 1; PCF = 32'h100;
        #1;
        chk("mr_idle_addr", MemAddr, 32'h100);
        chk("mr_idle_adv", {31'd0, Advance}, 32'd0);
        tick();
        chk("mr_fetch_adv", {31'd0, Advance}, 32'd1);
        tick();
        chk("mr_fetch_instr", InstrF, 32'h00500093);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
